// File: rtl/fifo_wr_burst.sv
// Burst write controller: moves a requested number of producer words into a FIFO.
// It stalls on empty source or full FIFO, supports early abort, and reports the count written.
module fifo_wr_burst #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk_wr,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  abort,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  input  logic                  full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  wr_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0] wr_count_q, wr_count_d;
  logic                 aborted_q, aborted_d;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wr_count_d  = wr_count_q;
    aborted_d   = aborted_q;
    wr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = burst_len;
          wr_count_d  = '0;
          aborted_d   = 1'b0;
          state_d     = (burst_len != '0) ? ST_BURST : ST_DONE;
        end
      end
      ST_BURST: begin
        // Abort wins over a write, including the final one.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (src_valid && !full && !rst) begin
          wr_en       = 1'b1;
          remaining_d = remaining_q - 1'b1;
          wr_count_d  = wr_count_q + 1'b1;
          if (remaining_q == LEN_WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_wr) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      wr_count_q  <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wr_count_q  <= wr_count_d;
      aborted_q   <= aborted_d;
    end
  end

  assign src_ready = wr_en;
  assign data_in   = src_data;
  assign busy      = (state_q == ST_BURST);
  assign done      = (state_q == ST_DONE);
  assign aborted   = aborted_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_burst.sv
// Scoreboard bench for fifo_wr_burst: a transaction-level model predicts FIFO
// writes and burst completions; a negedge monitor matches them against the DUT.
module tb_fifo_wr_burst;

  logic       clk_wr = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] burst_len;
  logic       abort;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic       full;
  logic       wr_en;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] wr_count;

  fifo_wr_burst #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk_wr(clk_wr), .rst(rst), .start(start), .burst_len(burst_len),
    .abort(abort), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .full(full), .wr_en(wr_en), .data_in(data_in),
    .busy(busy), .done(done), .aborted(aborted), .wr_count(wr_count)
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct packed {
    logic [7:0] count;
    logic       was_aborted;
  } completion_t;

  logic [7:0]  exp_data_q[$];
  completion_t exp_done_q[$];

  int checks = 0;
  int errors = 0;

  // Model: 0 = idle, 1 = burst in progress, 2 = completion cycle.
  int         m_phase = 0;
  int         m_left  = 0;
  logic [7:0] m_cnt   = '0;
  logic       m_ab    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT writes or signals done.
  always @(negedge clk_wr) begin
    if (rst === 1'b0) begin
      if (wr_en === 1'b1) begin
        check("src_ready_eq_wr_en", src_ready, 1'b1);
        if (exp_data_q.size() == 0) check("unexpected_write", 1'b1, 1'b0);
        else check("write_data", data_in, exp_data_q.pop_front());
      end
      if (done === 1'b1) begin
        if (exp_done_q.size() == 0) check("unexpected_done", 1'b1, 1'b0);
        else begin
          completion_t c;
          c = exp_done_q.pop_front();
          check("done_wr_count", wr_count, c.count);
          check("done_aborted", aborted, c.was_aborted);
        end
      end
    end
  end

  // One clock cycle: entered at posedge+1, drives inputs, predicts, advances.
  task automatic cyc(input logic st, input logic [7:0] len, input logic ab,
                     input logic sv, input logic [7:0] sd, input logic fl);
    int nxt;
    check("busy", busy, m_phase == 1);
    check("done", done, m_phase == 2);
    if (m_phase == 0) begin
      check("idle_wr_count_hold", wr_count, m_cnt);
      check("idle_aborted_hold", aborted, m_ab);
    end
    start = st; burst_len = len; abort = ab;
    src_valid = sv; src_data = sd; full = fl;
    nxt = m_phase;
    case (m_phase)
      0: if (st) begin
           m_cnt = '0;
           m_ab  = 1'b0;
           if (len == 0) begin
             nxt = 2;
             exp_done_q.push_back('{count: 8'd0, was_aborted: 1'b0});
           end else begin
             nxt = 1;
             m_left = len;
           end
         end
      1: if (ab) begin
           m_ab = 1'b1;
           nxt  = 2;
           exp_done_q.push_back('{count: m_cnt, was_aborted: 1'b1});
         end else if (sv && !fl) begin
           exp_data_q.push_back(sd);
           m_cnt++;
           m_left--;
           if (m_left == 0) begin
             nxt = 2;
             exp_done_q.push_back('{count: m_cnt, was_aborted: 1'b0});
           end
         end
      default: nxt = 0;
    endcase
    @(posedge clk_wr);
    #1;
    m_phase = nxt;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    start = 1'b1; burst_len = 8'd5; abort = 1'b0;
    src_valid = 1'b1; src_data = 8'hA5; full = 1'b0;
    #1;
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_src_ready", src_ready, 1'b0);
    repeat (cycles) @(posedge clk_wr);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr_en_after", wr_en, 1'b0);
    check("rst_wr_count", wr_count, 8'd0);
    check("rst_aborted", aborted, 1'b0);
    rst = 1'b0;
    start = 1'b0; src_valid = 1'b0;
    m_phase = 0; m_left = 0; m_cnt = '0; m_ab = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 1'b0, 1'b1, 8'($urandom), 1'b0);
  endtask

  initial begin
    int guard;
    logic [7:0] len;
    rst = 1'b1; start = 1'b0; burst_len = '0; abort = 1'b0;
    src_valid = 1'b0; src_data = '0; full = 1'b0;
    @(posedge clk_wr);
    #1;
    do_reset(2);
    idle(2);

    // Plain burst of 4, start re-asserted while busy.
    cyc(1, 8'd4, 0, 1, 8'h00, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'd9, 0, 1, 8'h10 + 8'(i), 0);
    cyc(1, 8'd7, 0, 1, 8'h55, 0);
    idle(2);

    // Length 3 with FIFO full for two cycles after the first write.
    cyc(1, 8'd3, 0, 0, 8'h00, 0);
    cyc(0, 8'd0, 0, 1, 8'h21, 0);
    cyc(0, 8'd0, 0, 1, 8'h22, 1);
    cyc(0, 8'd0, 0, 1, 8'h23, 1);
    cyc(0, 8'd0, 0, 1, 8'h24, 0);
    cyc(0, 8'd0, 0, 1, 8'h25, 0);
    cyc(0, 8'd0, 0, 0, 8'h00, 0);
    idle(2);

    // Length 10 aborted after five writes, with valid data in the abort cycle.
    cyc(1, 8'd10, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'd0, 0, 1, 8'h30 + 8'(i), 0);
    cyc(0, 8'd0, 1, 1, 8'hEE, 0);
    cyc(0, 8'd0, 0, 0, 8'h00, 0);
    idle(2);

    // Zero-length burst.
    cyc(1, 8'd0, 0, 1, 8'h77, 0);
    cyc(0, 8'd0, 0, 1, 8'h78, 0);
    idle(2);

    // Abort coinciding with the final write.
    cyc(1, 8'd2, 0, 0, 8'h00, 0);
    cyc(0, 8'd0, 0, 1, 8'h41, 0);
    cyc(0, 8'd0, 1, 1, 8'h42, 0);
    cyc(0, 8'd0, 0, 0, 8'h00, 0);
    idle(1);

    // Reset mid-burst, then a clean length-2 burst.
    cyc(1, 8'd8, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'd0, 0, 1, 8'h50 + 8'(i), 0);
    do_reset(1);
    idle(1);
    cyc(1, 8'd2, 0, 0, 8'h00, 0);
    cyc(0, 8'd0, 0, 1, 8'h61, 0);
    cyc(0, 8'd0, 0, 1, 8'h62, 0);
    cyc(0, 8'd0, 0, 0, 8'h00, 0);
    idle(2);

    // Maximum length burst.
    cyc(1, 8'd255, 0, 0, 8'h00, 0);
    for (int i = 0; i < 255; i++) cyc(0, 8'd0, 0, 1, 8'(i * 7), 0);
    cyc(0, 8'd0, 0, 0, 8'h00, 0);
    idle(2);

    // Randomized bursts with stalls, aborts and spurious starts.
    for (int b = 0; b < 60; b++) begin
      len = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
      cyc(1, len, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      guard = 0;
      while (m_phase != 0 && guard < 1000) begin
        cyc($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 29) == 0,
            $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0);
        guard++;
      end
      if (m_phase != 0) begin
        checks++;
        errors++;
        $display("FAIL burst_timeout: burst %0d still open after %0d cycles", b, guard);
      end
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("pending_writes", exp_data_q.size(), 0);
    check("pending_done", exp_done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_burst.md
FIFO_WR_BURST -- requirements
Module: fifo_wr_burst

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of write data (matches FIFO data width).
REQ-002 Parameter LEN_WIDTH, default 8, width of burst length and write counter.
REQ-003 clk_wr  input  1  write-domain clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  burst request, sampled in IDLE only.
REQ-006 burst_len  input  LEN_WIDTH  number of words to write, sampled with start.
REQ-007 abort  input  1  terminate the current burst early.
REQ-008 src_valid  input  1  producer has a word on src_data.
REQ-009 src_data  input  DATA_WIDTH  producer word.
REQ-010 src_ready  output  1  word on src_data is consumed this cycle.
REQ-011 full  input  1  FIFO full flag, write domain.
REQ-012 wr_en  output  1  FIFO write enable.
REQ-013 data_in  output  DATA_WIDTH  FIFO write data.
REQ-014 busy  output  1  high in BURST state.
REQ-015 done  output  1  one-cycle pulse at burst completion or abort.
REQ-016 aborted  output  1  last burst ended by abort; valid with done, held until next accepted start.
REQ-017 wr_count  output  LEN_WIDTH  words written in current/last burst.

Function
REQ-018 The FSM SHALL have states IDLE, BURST, DONE; encoding is free.
REQ-019 IDLE: start=1 and burst_len!=0 -> BURST next cycle; remaining<=burst_len, wr_count<=0, aborted<=0.
REQ-020 IDLE: start=1 and burst_len==0 -> DONE next cycle, no writes, wr_count<=0, aborted<=0.
REQ-021 start SHALL be ignored in BURST and DONE.
REQ-022 In BURST, wr_en = src_valid & ~full, combinational; src_ready SHALL equal wr_en; data_in SHALL equal src_data.
REQ-023 Outside BURST, wr_en and src_ready SHALL be 0; data_in value is don't-care.
REQ-024 Each cycle with wr_en=1: remaining decrements by 1, wr_count increments by 1.
REQ-025 A write with remaining==1 SHALL be the last; next state DONE.
REQ-026 full=1 or src_valid=0 SHALL stall with no write and counters held; no timeout.
REQ-027 abort=1 in BURST -> DONE next cycle, aborted<=1; no write occurs that cycle (wr_en forced 0).
REQ-028 abort SHALL have priority over the last-write completion in the same cycle.
REQ-029 DONE lasts exactly one cycle with done=1, then IDLE; start in DONE is ignored.
REQ-030 wr_count and aborted SHALL hold their value in IDLE until the next accepted start.
REQ-031 busy = (state==BURST); done = (state==DONE).
REQ-032 burst_len = 2^LEN_WIDTH-1 SHALL be supported without counter overflow.

Reset
REQ-033 rst=1 at a clock edge -> state IDLE, remaining=0, wr_count=0, aborted=0; takes priority over all inputs.
REQ-034 During and after reset: busy=0, done=0, wr_en=0, src_ready=0.
REQ-035 Reset asserted mid-burst SHALL abandon the burst with no done pulse.

Verification
REQ-036 start, burst_len=4, src_valid=1, full=0 -> wr_en high 4 consecutive cycles, data passed through, done pulse next cycle, wr_count=4, aborted=0.
REQ-037 burst_len=3, full=1 for 2 cycles after first write -> wr_en=0 while full, 3 writes total, wr_count=3, done once.
REQ-038 burst_len=10, abort after 5 writes -> no write in abort cycle, done pulse, aborted=1, wr_count=5.
REQ-039 start with burst_len=0 -> done pulse 1 cycle later, no wr_en, wr_count=0.
REQ-040 rst during burst (len=8, 3 written) -> IDLE next cycle, wr_count=0, no done; following start len=2 completes normally.
REQ-041 start while busy or in DONE -> ignored; wr_count reflects only original burst.
